serial_adder: RTL and testbench
===============================

# serial_adder

Bit-serial adder: accepts two WIDTH-bit operands plus carry-in on a start strobe, then resolves one bit per clock, LSB first, through a single registered-carry full adder. It sits directly downstream of the combinational full adder cell and is the area-minimal alternative to a ripple-carry array. It is intended for low-rate datapaths where one adder cell time-shared over WIDTH cycles beats WIDTH cells.

## Interface
- WIDTH, default 8: operand/result width in bits, WIDTH >= 1.
- clk  input  1  sole clock; all state updates on the rising edge.
- rst  input  1  reset; synchronous, active-high.
- start  input  1  request to begin an addition; sampled only when the block is accepting.
- a  input  WIDTH  operand A; captured on accepted start.
- b  input  WIDTH  operand B; captured on accepted start.
- cin  input  1  carry-in; captured on accepted start.
- busy  output  1  high while an addition is in progress.
- done  output  1  one-cycle pulse; result is valid.
- sum  output  WIDTH  result; held until the next accepted start.
- cout  output  1  carry-out of the MSB; held with sum.
- ovf  output  1  signed overflow; present only with SERIAL_ADDER_OVF_EN.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: busy=0, done=0. start=1 -> capture a, b, cin into shift registers, clear bit counter, go RUN.
- RUN: busy=1. Each cycle, the full adder takes LSB of A reg, LSB of B reg, carry reg.
  - Sum bit shifts into the MSB of the sum reg, which shifts right.
  - Carry reg takes the cell's cout.
  - A and B regs shift right.
  - Counter increments. After the cycle that processes bit WIDTH-1 -> DONE.
- DONE: done=1, busy=0, sum/cout registered outputs updated this cycle. Next cycle -> IDLE, unless start=1, in which case capture new operands and go RUN directly (back-to-back).
- start in RUN: ignored; operands not re-captured.
- Arithmetic: {cout, sum} = a + b + cin, unsigned, modulo 2^(WIDTH+1). No saturation.
- Counter width: clog2 of WIDTH, minimum 1 bit. WIDTH=1 gives exactly one RUN cycle.
- a/b/cin may change freely after the capture cycle.

## Timing
- Reset values: busy=0, done=0, sum=0, cout=0, ovf=0. State=IDLE, counter=0, carry reg=0.
- Latency: start high at edge N (accepted) -> busy high from N+1. done high for exactly the cycle after edge N+WIDTH+1. Sum/cout are valid from that cycle.
- Throughput: one result per WIDTH+1 cycles with back-to-back start.
- rst mid-operation: next edge forces IDLE and all reset values. The in-flight addition is discarded, and no done is issued.
- rst and start simultaneously: rst wins; start is not accepted.
- sum/cout change only in the DONE cycle or on reset. They are stable between completions.

## Configuration
- SERIAL_ADDER_OVF_EN defined: ovf port exists.
  - ovf = carry into MSB XOR carry out of MSB, sampled during the final RUN cycle.
  - ovf is registered alongside sum/cout, with the same validity and hold rules.
- Undefined: no ovf port, no extra flop; the rest is identical.

## Structure
- Shared math package/include: the state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the clog2 helper function.
- One sub-module: full_adder, instantiated once as the per-bit cell. It is the only combinational arithmetic in the block.
- Everything else in serial_adder: FSM, counter, the A/B/sum shift registers, the carry register, and the output registers.

## Test plan
- WIDTH=8, a=0x5A, b=0x3C, cin=0, start at edge 0 -> busy edges 1–8, done at cycle after edge 9, sum=0x96, cout=0.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Also a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
- start pulsed again at edge 4 with a=0x11, b=0x22 -> ignored; the first result is delivered unchanged.
- rst asserted at edge 5 of a run -> busy=0 and sum=0 next cycle; no done pulse follows.
- Back-to-back: start held high through DONE with the next operands (0x01+0x02) -> done pulses WIDTH+1 cycles apart, results 0x96 then 0x03.
- SERIAL_ADDER_OVF_EN, a=0x7F, b=0x01, cin=0 -> sum=0x80, cout=0, ovf=1. Also a=0x80, b=0x80 -> sum=0x00, cout=1, ovf=1. WIDTH=1 build: a=1, b=1, cin=1 -> sum=1, cout=1, done at cycle after edge 2.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encodings and a clog2 helper.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Ceiling log2, never less than 1 so a counter always has at least one bit.
    function automatic int unsigned clog2_min1(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < v) begin
                r = i + 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/serial_adder_full_adder.sv
// Single-bit full adder cell, time-shared by serial_adder across all operand bits.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic sum_c,
    output logic cout_c
);

    assign sum_c  = a ^ b ^ ci;
    assign cout_c = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one registered-carry full adder resolves {cout, sum} = a + b + cin LSB first.
// Optional signed-overflow output is enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned CNT_W = clog2_min1(WIDTH);

    state_t             state;
    state_t             state_nxt;
    logic [WIDTH-1:0]   a_sr;
    logic [WIDTH-1:0]   b_sr;
    logic [WIDTH-1:0]   sum_sr;
    logic               carry;
    logic [CNT_W-1:0]   cnt;
    logic               load;
    logic               shift;
    logic               last;
    logic               fa_sum;
    logic               fa_cout;

    full_adder u_fa (
        .a      (a_sr[0]),
        .b      (b_sr[0]),
        .ci     (carry),
        .sum_c  (fa_sum),
        .cout_c (fa_cout)
    );

    assign last = (cnt == CNT_W'(WIDTH - 1));

    // Next-state and datapath control
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        shift     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                shift = 1'b1;
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, shift registers, carry, counter and status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            a_sr   <= '0;
            b_sr   <= '0;
            sum_sr <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            sum    <= '0;
            cout   <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state == RUN);
            done  <= (state == DONE);
            if (state == DONE) begin
                sum  <= sum_sr;
                cout <= carry;
            end
            if (load) begin
                a_sr  <= a;
                b_sr  <= b;
                carry <= cin;
                cnt   <= '0;
            end else if (shift) begin
                a_sr   <= a_sr >> 1;
                b_sr   <= b_sr >> 1;
                sum_sr <= (sum_sr >> 1) | (WIDTH'(fa_sum) << (WIDTH - 1));
                carry  <= fa_cout;
                cnt    <= cnt + CNT_W'(1);
            end
        end
    end

`ifdef SERIAL_ADDER_OVF_EN
    logic ovf_bit;

    // Overflow is carry into the MSB xor carry out of it, taken on the final bit
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_bit <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            if (shift && last) begin
                ovf_bit <= carry ^ fa_cout;
            end
            if (state == DONE) begin
                ovf <= ovf_bit;
            end
        end
    end
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder (WIDTH=8 and WIDTH=1 instances).
// Define SERIAL_ADDER_OVF_EN to also check the overflow output.
module tb_serial_adder;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;

    logic       start1;
    logic [0:0] a1;
    logic [0:0] b1;
    logic       cin1;
    logic       busy1;
    logic       done1;
    logic [0:0] sum1;
    logic       cout1;
    logic       ovf1;

    int n_cmp;
    int n_bad;

    serial_adder #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk   (clk),
        .rst   (rst),
        .start (start1),
        .a     (a1),
        .b     (b1),
        .cin   (cin1),
        .busy  (busy1),
        .done  (done1),
        .sum   (sum1),
        .cout  (cout1)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf   (ovf1)
`endif
    );

`ifndef SERIAL_ADDER_OVF_EN
    assign ovf  = 1'b0;
    assign ovf1 = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_ovf(input string tag, input logic obs, input logic exp);
`ifdef SERIAL_ADDER_OVF_EN
        chk(tag, 32'(obs), 32'(exp));
`endif
    endtask

    // Start from idle at edge 0; optionally pulse start with other operands before edge pulse_at
    task automatic run_add(input string tag, input logic [7:0] ta, input logic [7:0] tb_v,
                           input logic tc, input logic [7:0] es, input logic ec,
                           input logic eo, input int pulse_at);
        a = ta; b = tb_v; cin = tc; start = 1'b1;
        tick();
        start = 1'b0;
        a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
        for (int i = 1; i <= 8; i++) begin
            if (i == pulse_at) begin
                start = 1'b1; a = 8'h11; b = 8'h22;
            end
            tick();
            start = 1'b0;
            chk({tag, "_busy"}, 32'(busy), 32'd1);
            chk({tag, "_nodone"}, 32'(done), 32'd0);
        end
        tick();
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_busy_lo"}, 32'(busy), 32'd0);
        chk({tag, "_sum"}, 32'(sum), 32'(es));
        chk({tag, "_cout"}, 32'(cout), 32'(ec));
        chk_ovf({tag, "_ovf"}, ovf, eo);
        tick();
        chk({tag, "_done_pulse"}, 32'(done), 32'd0);
        chk({tag, "_sum_hold"}, 32'(sum), 32'(es));
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
        tick();
        tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        chk_ovf("rst_ovf", ovf, 1'b0);
        rst = 1'b0;
        tick();
        chk("idle_busy", 32'(busy), 32'd0);

        run_add("add_5a_3c", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1, 0);
        run_add("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 0);
        run_add("add_ff_ff_c", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 0);
        run_add("ign_start", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1, 4);

        // Reset in the middle of a run discards it
        a = 8'hFF; b = 8'hFF; cin = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i <= 4; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_sum", 32'(sum), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("midrst_nodone", 32'(done), 32'd0);
        end

        // Reset and start together: reset wins
        rst = 1'b1; start = 1'b1; a = 8'h01; b = 8'h01;
        tick();
        rst = 1'b0; start = 1'b0;
        chk("rst_start_busy0", 32'(busy), 32'd0);
        tick();
        chk("rst_start_busy1", 32'(busy), 32'd0);
        tick();
        chk("rst_start_busy2", 32'(busy), 32'd0);

        // Back-to-back: new start during the DONE state
        a = 8'h5A; b = 8'h3C; cin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i <= 8; i++) tick();
        a = 8'h01; b = 8'h02; cin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        chk("b2b_done1", 32'(done), 32'd1);
        chk("b2b_sum1", 32'(sum), 32'h96);
        for (int i = 10; i <= 17; i++) begin
            tick();
            chk("b2b_gap", 32'(done), 32'd0);
        end
        tick();
        chk("b2b_done2", 32'(done), 32'd1);
        chk("b2b_sum2", 32'(sum), 32'h03);
        chk("b2b_cout2", 32'(cout), 32'd0);
        tick();

        run_add("add_7f_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 0);
        run_add("add_80_80", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 0);

        // WIDTH=1 instance: one RUN cycle, done after edge 2
        a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1; start1 = 1'b1;
        tick();
        start1 = 1'b0; a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
        chk("w1_busy_e0", 32'(busy1), 32'd0);
        tick();
        chk("w1_busy_e1", 32'(busy1), 32'd1);
        chk("w1_nodone_e1", 32'(done1), 32'd0);
        tick();
        chk("w1_done", 32'(done1), 32'd1);
        chk("w1_sum", 32'(sum1), 32'd1);
        chk("w1_cout", 32'(cout1), 32'd1);
        chk_ovf("w1_ovf", ovf1, 1'b0);
        tick();
        chk("w1_done_pulse", 32'(done1), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
